// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-wide memory port arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 3;

  localparam logic [CNT_W-1:0] IF_LEN = CNT_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    MM_RD = 2'd2,
    MM_WR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_H = 2'b01,
    LEN_W = 2'b10
  } len_e;

  // Byte count of an MM access; the unused code 11 behaves as a word.
  function automatic logic [CNT_W-1:0] len_to_n(input logic [1:0] len);
    case (len_e'(len))
      LEN_B:   return CNT_W'(1);
      LEN_H:   return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request/response and external memory pin bundle for mem_arb.
interface mem_arb_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_a;
  logic              if_clr;
  logic              if_ok;
  logic [DATA_W-1:0] if_dt;

  logic              mm_req;
  logic              mm_wr;
  logic [1:0]        mm_len;
  logic [ADDR_W-1:0] mm_a;
  logic [DATA_W-1:0] mm_wn;
  logic              mm_ok;
  logic [DATA_W-1:0] mm_dt;

  logic [7:0]        rom_rn;
  logic [7:0]        rom_wn;
  logic [ADDR_W-1:0] rom_a;
  logic              rom_wr;
  logic              busy;

  modport slave (
    input  if_req, if_a, if_clr, mm_req, mm_wr, mm_len, mm_a, mm_wn, rom_rn,
    output if_ok, if_dt, mm_ok, mm_dt, rom_wn, rom_a, rom_wr, busy
  );

  modport master (
    output if_req, if_a, if_clr, mm_req, mm_wr, mm_len, mm_a, mm_wn, rom_rn,
    input  if_ok, if_dt, mm_ok, mm_dt, rom_wn, rom_a, rom_wr, busy
  );

endinterface

// File: rtl/mem_arb.sv
// Arbitrates fetch and memory-stage accesses onto one byte-wide memory port,
// sequencing 32-bit accesses as little-endian byte transfers.
module mem_arb
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              last_mm_q, last_mm_d;
  logic [DATA_W-1:0] lanes_q, lanes_d;
  logic [23:0]       wdat_q, wdat_d;
  logic              if_ok_q, if_ok_d;
  logic [DATA_W-1:0] if_dt_q, if_dt_d;
  logic              mm_ok_q, mm_ok_d;
  logic [DATA_W-1:0] mm_dt_q, mm_dt_d;
  logic [7:0]        rom_wn_q, rom_wn_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;
  logic              rom_wr_q, rom_wr_d;
  logic              busy_q, busy_d;

  logic              if_go, mm_go;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] lanes_ins;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      last_mm_q <= 1'b0;
      lanes_q   <= '0;
      wdat_q    <= '0;
      if_ok_q   <= 1'b0;
      if_dt_q   <= '0;
      mm_ok_q   <= 1'b0;
      mm_dt_q   <= '0;
      rom_wn_q  <= '0;
      rom_a_q   <= '0;
      rom_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      last_mm_q <= last_mm_d;
      lanes_q   <= lanes_d;
      wdat_q    <= wdat_d;
      if_ok_q   <= if_ok_d;
      if_dt_q   <= if_dt_d;
      mm_ok_q   <= mm_ok_d;
      mm_dt_q   <= mm_dt_d;
      rom_wn_q  <= rom_wn_d;
      rom_a_q   <= rom_a_d;
      rom_wr_q  <= rom_wr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    last_mm_d = last_mm_q;
    lanes_d   = lanes_q;
    wdat_d    = wdat_q;
    if_ok_d   = 1'b0;
    if_dt_d   = if_dt_q;
    mm_ok_d   = 1'b0;
    mm_dt_d   = mm_dt_q;
    rom_wn_d  = rom_wn_q;
    rom_a_d   = rom_a_q;
    rom_wr_d  = 1'b0;

    // A requester whose ok is showing this cycle is still holding its old request.
    if_go   = bus.if_req && !bus.if_clr && !if_ok_q;
    mm_go   = bus.mm_req && !mm_ok_q;
    cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

    // Byte returned now belongs to the address issued one cycle earlier.
    lanes_ins = lanes_q;
    case (cnt_q)
      3'd1:    lanes_ins[7:0]   = bus.rom_rn;
      3'd2:    lanes_ins[15:8]  = bus.rom_rn;
      3'd3:    lanes_ins[23:16] = bus.rom_rn;
      3'd4:    lanes_ins[31:24] = bus.rom_rn;
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (mm_go && (!if_go || !last_mm_q)) begin
          state_d   = bus.mm_wr ? MM_WR : MM_RD;
          n_d       = len_to_n(bus.mm_len);
          cnt_d     = '0;
          lanes_d   = '0;
          rom_a_d   = bus.mm_a;
          last_mm_d = 1'b1;
          if (bus.mm_wr) begin
            rom_wr_d = 1'b1;
            rom_wn_d = bus.mm_wn[7:0];
            wdat_d   = bus.mm_wn[31:8];
          end
        end else if (if_go) begin
          state_d   = IF_RD;
          n_d       = IF_LEN;
          cnt_d     = '0;
          lanes_d   = '0;
          rom_a_d   = bus.if_a;
          last_mm_d = 1'b0;
        end
      end

      IF_RD, MM_RD: begin
        if (state_q == IF_RD && bus.if_clr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          lanes_d = lanes_ins;
          cnt_d   = cnt_inc;
          if (cnt_inc < n_q) rom_a_d = rom_a_q + ADDR_W'(1);
          if (cnt_q == n_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IF_RD) begin
              if_ok_d = 1'b1;
              if_dt_d = lanes_ins;
            end else begin
              mm_ok_d = 1'b1;
              mm_dt_d = lanes_ins;
            end
          end
        end
      end

      MM_WR: begin
        if (cnt_q == CNT_W'(n_q - CNT_W'(1))) begin
          state_d = IDLE;
          cnt_d   = '0;
          mm_ok_d = 1'b1;
        end else begin
          rom_wr_d = 1'b1;
          rom_a_d  = rom_a_q + ADDR_W'(1);
          rom_wn_d = wdat_q[7:0];
          wdat_d   = {8'h00, wdat_q[23:8]};
          cnt_d    = cnt_inc;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.if_ok  = if_ok_q;
  assign bus.if_dt  = if_dt_q;
  assign bus.mm_ok  = mm_ok_q;
  assign bus.mm_dt  = mm_dt_q;
  assign bus.rom_wn = rom_wn_q;
  assign bus.rom_a  = rom_a_q;
  assign bus.rom_wr = rom_wr_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: byte-memory model on the rom pins, directed
// timing scenarios, then randomized concurrent IF/MM traffic.
module tb_mem_arb;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(AW)) bus ();
  mem_arb #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] dt; int run; bit chk_dt; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wexp_t;

  exp_t  if_q[$];
  exp_t  mm_q[$];
  wexp_t w_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    busy_run = 0;
  string order    = "";

  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  // Initial image of every byte not explicitly written.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s required=%s t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_mem(input logic [31:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Byte-wide synchronous memory: read data follows the address by one cycle.
  initial forever begin
    @(posedge clk);
    bus.rom_rn <= env_rd(bus.rom_a);
    if (bus.rom_wr) mem[bus.rom_a] = bus.rom_wn;
  end

  // Monitor: pops expectations whenever the DUT completes or writes a byte.
  initial forever begin
    exp_t  e;
    wexp_t w;
    @(negedge clk);
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (bus.if_ok) begin
        chk("if_ok_expected", 32'(if_q.size() != 0), 32'd1);
        if (if_q.size() != 0) begin
          e = if_q.pop_front();
          chk("if_dt", bus.if_dt, e.dt);
          chk("if_busy_cycles", 32'(busy_run), 32'(e.run));
        end
        order = {order, "I"};
      end
      if (bus.mm_ok) begin
        chk("mm_ok_expected", 32'(mm_q.size() != 0), 32'd1);
        if (mm_q.size() != 0) begin
          e = mm_q.pop_front();
          if (e.chk_dt) chk("mm_dt", bus.mm_dt, e.dt);
          chk("mm_busy_cycles", 32'(busy_run), 32'(e.run));
        end
        order = {order, "M"};
      end
      if (bus.rom_wr) begin
        chk("rom_wr_expected", 32'(w_q.size() != 0), 32'd1);
        if (w_q.size() != 0) begin
          w = w_q.pop_front();
          chk("rom_a_write", bus.rom_a, w.a);
          chk("rom_wn", 32'(bus.rom_wn), 32'(w.d));
        end
      end
      busy_run = bus.busy ? busy_run + 1 : 0;
    end
  end

  task automatic issue_if(input logic [31:0] a);
    exp_t e;
    e.dt = {ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)};
    e.run = 5;
    e.chk_dt = 1'b1;
    if_q.push_back(e);
    bus.if_a   = a;
    bus.if_req = 1'b1;
  endtask

  task automatic issue_mm(input bit wr, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wn, input bit track);
    exp_t  e;
    wexp_t w;
    int    n;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    e.dt = '0;
    e.run = wr ? n : n + 1;
    e.chk_dt = !wr;
    for (int j = 0; j < n; j++) begin
      if (wr) begin
        w.a = a + 32'(j);
        w.d = wn[8*j +: 8];
        w_q.push_back(w);
        if (track) ref_mem[w.a] = w.d;
      end else begin
        e.dt[8*j +: 8] = ref_rd(a + 32'(j));
      end
    end
    mm_q.push_back(e);
    bus.mm_wr  = wr;
    bus.mm_len = len;
    bus.mm_a   = a;
    bus.mm_wn  = wn;
    bus.mm_req = 1'b1;
  endtask

  // Waits (bounded) for the requester's ok, returns cycles taken, drops the request.
  task automatic wait_ok(input bit is_if, output int lat);
    lat = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (is_if ? bus.if_ok : bus.mm_ok) begin
        lat = t;
        break;
      end
    end
    chk(is_if ? "if_ok_within_bound" : "mm_ok_within_bound", 32'(lat != 0), 32'd1);
    if (is_if) bus.if_req = 1'b0;
    else bus.mm_req = 1'b0;
  endtask

  task automatic run_both(input string exp_order, input logic [31:0] ia, input logic [31:0] ma);
    bit di, dm;
    order = "";
    di = 1'b0;
    dm = 1'b0;
    issue_if(ia);
    issue_mm(1'b0, 2'b10, ma, 32'h0, 1'b1);
    for (int t = 0; t < 100 && !(di && dm); t++) begin
      @(negedge clk);
      if (bus.if_ok) begin bus.if_req = 1'b0; di = 1'b1; end
      if (bus.mm_ok) begin bus.mm_req = 1'b0; dm = 1'b1; end
    end
    chk("both_served", 32'({di, dm}), 32'd3);
    chk_str("grant_order", order, exp_order);
  endtask

  initial begin
    int lat;
    int okc;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_a = '0; bus.if_clr = 1'b0;
    bus.mm_req = 1'b0; bus.mm_wr = 1'b0; bus.mm_len = '0; bus.mm_a = '0; bus.mm_wn = '0;
    repeat (3) @(negedge clk);
    chk("rst_if_ok", 32'(bus.if_ok), 32'd0);
    chk("rst_if_dt", bus.if_dt, 32'd0);
    chk("rst_mm_ok", 32'(bus.mm_ok), 32'd0);
    chk("rst_mm_dt", bus.mm_dt, 32'd0);
    chk("rst_rom_wn", 32'(bus.rom_wn), 32'd0);
    chk("rst_rom_a", bus.rom_a, 32'd0);
    chk("rst_rom_wr", 32'(bus.rom_wr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Byte write: one strobe cycle, ok the cycle after.
    issue_mm(1'b1, 2'b00, 32'h20, 32'hAABBCCDD, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("bw_rom_wr_c1", 32'(bus.rom_wr), 32'd1);
        chk("bw_rom_a_c1", bus.rom_a, 32'h20);
        chk("bw_rom_wn_c1", 32'(bus.rom_wn), 32'hDD);
        chk("bw_busy_c1", 32'(bus.busy), 32'd1);
      end else if (c == 2) begin
        chk("bw_mm_ok_c2", 32'(bus.mm_ok), 32'd1);
        chk("bw_rom_wr_c2", 32'(bus.rom_wr), 32'd0);
        chk("bw_busy_c2", 32'(bus.busy), 32'd0);
        bus.mm_req = 1'b0;
      end else begin
        chk("bw_rom_wr_c3", 32'(bus.rom_wr), 32'd0);
        chk("bw_mm_ok_c3", 32'(bus.mm_ok), 32'd0);
      end
    end

    // Half read at 0x7: ok in C4.
    set_mem(32'h7, 8'h34);
    set_mem(32'h8, 8'h12);
    issue_mm(1'b0, 2'b01, 32'h7, 32'h0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) chk("hr_mm_ok_c3", 32'(bus.mm_ok), 32'd0);
      if (c == 4) begin
        chk("hr_mm_ok_c4", 32'(bus.mm_ok), 32'd1);
        chk("hr_mm_dt", bus.mm_dt, 32'h0000_1234);
        bus.mm_req = 1'b0;
      end
    end

    // IF word read at 0x100 with exact address and busy timing.
    set_mem(32'h100, 8'h13);
    set_mem(32'h101, 8'h05);
    set_mem(32'h102, 8'h00);
    set_mem(32'h103, 8'h00);
    issue_if(32'h100);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) chk($sformatf("if_rom_a_c%0d", c), bus.rom_a, 32'h100 + 32'(c - 1));
      chk($sformatf("if_busy_c%0d", c), 32'(bus.busy), 32'(c <= 5));
      chk($sformatf("if_ok_c%0d", c), 32'(bus.if_ok), 32'(c == 6));
      if (c == 6) begin
        chk("if_dt_0x100", bus.if_dt, 32'h0000_0513);
        bus.if_req = 1'b0;
      end
    end
    @(negedge clk);

    // Contention: last grant IF -> MM first; after an MM-only access -> IF first.
    run_both("MI", 32'h1000_0040, 32'h2000_0010);
    @(negedge clk);
    issue_mm(1'b1, 2'b10, 32'h2000_0020, 32'h5566_7788, 1'b1);
    wait_ok(1'b0, lat);
    @(negedge clk);
    run_both("IM", 32'h1000_0044, 32'h2000_0020);
    @(negedge clk);

    // if_clr in C3 aborts the fetch; the next fetch is unaffected.
    bus.if_a   = 32'h1000_0080;
    bus.if_req = 1'b1;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    bus.if_clr = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("abort_busy_c4", 32'(bus.busy), 32'd0);
    bus.if_clr = 1'b0;
    okc = 0;
    repeat (6) begin
      @(negedge clk);
      okc += int'(bus.if_ok);
    end
    chk("abort_no_if_ok", 32'(okc), 32'd0);
    set_mem(32'h200, 8'h93);
    set_mem(32'h201, 8'h00);
    set_mem(32'h202, 8'h10);
    set_mem(32'h203, 8'h00);
    issue_if(32'h200);
    wait_ok(1'b1, lat);
    chk("if_0x200_latency", 32'(lat), 32'd6);

    // Asynchronous reset in the middle of a word write.
    @(negedge clk);
    issue_mm(1'b1, 2'b10, 32'h3000_0000, 32'h1122_3344, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_rom_wr", 32'(bus.rom_wr), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_mm_ok", 32'(bus.mm_ok), 32'd0);
    chk("arst_rom_a", bus.rom_a, 32'd0);
    bus.mm_req = 1'b0;
    w_q.delete();
    mm_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_mm_dt", bus.mm_dt, 32'd0);
    chk("post_rst_if_dt", bus.if_dt, 32'd0);
    run_both("MI", 32'h1000_0048, 32'h2000_0004);
    @(negedge clk);

    // Randomized concurrent traffic.
    fork
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue_if(32'h1000_0000 + 32'($urandom_range(0, 255)));
          wait_ok(1'b1, l);
        end
      end
      begin
        int l;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          else a = 32'h2000_0000 + 32'($urandom_range(0, 31));
          issue_mm(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 1'b1);
          wait_ok(1'b0, l);
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mm_q_drained", 32'(mm_q.size()), 32'd0);
    chk("w_q_drained", 32'(w_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t checks=%0d failures=%0d", $time, checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates the single byte-wide external memory port between instruction fetch (IF, word reads) and the memory stage (MM, 1/2/4-byte reads and writes).
- Sequences each 32-bit access as consecutive little-endian byte transfers and assembles or splits the data.
- Sits between the fetch/memory stages and the rom_* pins, replacing direct fetch-to-port wiring.

Parameters:
ADDR_W, 32, width of the byte address bus and request addresses.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  IF read request, held until if_ok or if_clr
if_a  in  ADDR_W  IF word byte address, stable while if_req
if_clr  in  1  abort in-flight or pending IF request (branch flush)
if_ok  out  1  one-cycle pulse, if_dt valid
if_dt  out  32  fetched word, little-endian
mm_req  in  1  MM request, held until mm_ok
mm_wr  in  1  1 = write, 0 = read
mm_len  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
mm_a  in  ADDR_W  MM byte address
mm_wn  in  32  write data, low bytes used
mm_ok  out  1  one-cycle pulse at completion
mm_dt  out  32  read data, zero-extended above len
rom_rn  in  8  memory read byte: mem[rom_a of previous cycle]
rom_wn  out  8  memory write byte
rom_a  out  ADDR_W  memory byte address
rom_wr  out  1  memory write strobe
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst low, async): state IDLE, all outputs 0, byte counter 0, fairness flag cleared.
- All outputs are registered.
- States: IDLE, IF_RD, MM_RD, MM_WR.
- Grant, evaluated in IDLE at the clock edge:
  - A req that is high in the same cycle as its own ok is masked (no double service).
  - if_req is masked while if_clr is high.
  - Both requesting: MM wins, unless the previous grant was MM, in which case IF wins (alternate on contention).
  - IF only or MM only: that requester is granted.
  - The state for the winning access is entered at the next edge; rom_a is loaded with the base address.
- Length n: IF = 4; MM = 1, 2 or 4 per mm_len.
- Reads (cycle C1 is the first busy cycle):
  - rom_a = base + j during cycle C(j+1), j = 0..n-1.
  - Byte j arrives on rom_rn in C(j+2) and is latched into lane j at the end of that cycle.
  - ok and data are visible in C(n+2); state is IDLE in that cycle.
  - Word read: 6 cycles from the grant edge to the ok cycle inclusive.
- Writes:
  - In C1..Cn, rom_wr = 1, rom_a = base + j, rom_wn = mm_wn[8j+7:8j].
  - In C(n+1), mm_ok = 1, rom_wr = 0, state IDLE.
- rom_wr is 0 in every non-write cycle; rom_a holds its last value while idle.
- Address arithmetic wraps modulo 2^ADDR_W; no alignment check.
- if_clr during IF_RD: next state IDLE, no if_ok, lanes discarded. if_clr in the cycle if_ok is high has no effect.
- MM accesses are never aborted; if_clr during an MM access has no effect on it.
- mm_dt and if_dt hold their values until the next completion of the same requester.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, IF_RD, MM_RD, MM_WR);
  - the mm_len codes (LEN_B, LEN_H, LEN_W);
  - a len_to_n function;
  - the constant IF_LEN = 4.
- No sub-module. The byte counter, lane capture and arbiter are a single FSM.

Test Plan:
- IF read at 0x100, mem = 13 05 00 00 -> rom_a 0x100..0x103 in C1..C4; if_ok in C6 with if_dt = 0x00000513; busy high in C1..C5.
- MM byte write, a = 0x20, mm_wn = 0xAABBCCDD -> a single cycle with rom_wr = 1, rom_a = 0x20, rom_wn = 0xDD; mm_ok in the next cycle; no other rom_wr.
- MM half read at 0x7 with bytes 34 12 -> mm_dt = 0x00001234; mm_ok in C4.
- if_req and mm_req both high in IDLE, then requests reissued -> MM served first, IF second, then MM again (alternation); neither requester is served twice per request.
- if_clr asserted in C3 of an IF read -> no if_ok; IDLE the next cycle; a new if_req at 0x200 completes normally.
- Reset asserted mid MM_WR -> rom_wr, ok and busy drop to 0 immediately (async); after release, state is IDLE and a fresh request is served normally.
